nts_dispatch_arbiter: RTL and testbench

Round-robin scheduler between the receive-side dispatch FIFO and `ENGINES` parallel `nts_engine` instances. It watches the upstream packet-available flag and picks the next idle engine. It then routes the FIFO read handshake and data of one packet to that engine only, and returns the engine's read/discard release upstream. Packets that find no idle engine within `DROP_TIMEOUT` cycles are discarded and counted.

---
 rtl/nts_dispatch_arbiter_if.sv | 79 +++++++
 rtl/nts_dispatch_arbiter.sv | 140 ++++++++++++++
 tb/tb_nts_dispatch_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nts_dispatch_arbiter_if.sv
// nts_dispatch_arbiter_if
//   Bundles the upstream dispatch-FIFO side and the per-engine side of the
//   dispatch arbiter, plus its statistics and busy flag.
//   slave  : the arbiter's view (drives o_* signals, samples i_* signals)
//   master : the environment's view (upstream FIFO + engines + monitors)
// Ports (signals):
//   o_busy                         arbiter not idle
//   i_dispatch_packet_available    upstream holds a complete packet
//   o_dispatch_packet_read_discard release current upstream packet
//   i_dispatch_data_valid [8]      byte-valid mask of last word
//   i_dispatch_fifo_empty          upstream FIFO empty
//   o_dispatch_fifo_rd_en          upstream FIFO pop
//   i_dispatch_fifo_rd_data [64]   upstream FIFO word
//   i_engine_busy [ENGINES]        per-engine busy
//   o_engine_packet_available      per-engine packet available
//   i_engine_packet_read_discard   per-engine release
//   o_engine_data_valid [8]        broadcast byte-valid mask
//   o_engine_fifo_empty            per-engine FIFO empty
//   i_engine_fifo_rd_en            per-engine pop
//   o_engine_fifo_rd_data [64]     broadcast FIFO word
//   o_stat_dispatched / o_stat_dropped [32] packet counters
interface nts_dispatch_arbiter_if #(
    parameter int ENGINES = 4
);
    logic                o_busy;
    logic                i_dispatch_packet_available;
    logic                o_dispatch_packet_read_discard;
    logic [7:0]          i_dispatch_data_valid;
    logic                i_dispatch_fifo_empty;
    logic                o_dispatch_fifo_rd_en;
    logic [63:0]         i_dispatch_fifo_rd_data;
    logic [ENGINES-1:0]  i_engine_busy;
    logic [ENGINES-1:0]  o_engine_packet_available;
    logic [ENGINES-1:0]  i_engine_packet_read_discard;
    logic [7:0]          o_engine_data_valid;
    logic [ENGINES-1:0]  o_engine_fifo_empty;
    logic [ENGINES-1:0]  i_engine_fifo_rd_en;
    logic [63:0]         o_engine_fifo_rd_data;
    logic [31:0]         o_stat_dispatched;
    logic [31:0]         o_stat_dropped;

    modport slave (
        output o_busy,
        input  i_dispatch_packet_available,
        output o_dispatch_packet_read_discard,
        input  i_dispatch_data_valid,
        input  i_dispatch_fifo_empty,
        output o_dispatch_fifo_rd_en,
        input  i_dispatch_fifo_rd_data,
        input  i_engine_busy,
        output o_engine_packet_available,
        input  i_engine_packet_read_discard,
        output o_engine_data_valid,
        output o_engine_fifo_empty,
        input  i_engine_fifo_rd_en,
        output o_engine_fifo_rd_data,
        output o_stat_dispatched,
        output o_stat_dropped
    );

    modport master (
        input  o_busy,
        output i_dispatch_packet_available,
        input  o_dispatch_packet_read_discard,
        output i_dispatch_data_valid,
        output i_dispatch_fifo_empty,
        input  o_dispatch_fifo_rd_en,
        output i_dispatch_fifo_rd_data,
        output i_engine_busy,
        input  o_engine_packet_available,
        output i_engine_packet_read_discard,
        input  o_engine_data_valid,
        input  o_engine_fifo_empty,
        output i_engine_fifo_rd_en,
        input  o_engine_fifo_rd_data,
        input  o_stat_dispatched,
        input  o_stat_dropped
    );
endinterface

// File: rtl/nts_dispatch_arbiter.sv
// nts_dispatch_arbiter
//   Round-robin scheduler between the receive dispatch FIFO and ENGINES
//   nts_engine instances. One upstream packet is routed to exactly one idle
//   engine; packets that find no idle engine within DROP_TIMEOUT cycles are
//   discarded and counted.
// Ports:
//   i_clk       system clock
//   i_areset_n  asynchronous reset, active low
//   bus         nts_dispatch_arbiter_if.slave (upstream, engine, stats)
module nts_dispatch_arbiter #(
    parameter int ENGINES      = 4,
    parameter int DROP_TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_areset_n,
    nts_dispatch_arbiter_if.slave  bus
);
    localparam int          SEL_W      = $clog2(ENGINES);
    localparam logic [15:0] TIMER_LAST = 16'(DROP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_GRANT,
        S_DROP,
        S_RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel, last, pick;
    logic               pick_vld;
    logic [15:0]        timer;
    logic [31:0]        cnt_disp, cnt_drop;

    logic [ENGINES-1:0] eng_avail, eng_empty;
    logic               up_rd_en, up_release;

    wire avail = bus.i_dispatch_packet_available;

    // First idle engine after 'last', wrapping modulo ENGINES.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int i = 1; i <= ENGINES; i++) begin
            idx  = (int'(last) + i) % ENGINES;
            cand = SEL_W'(idx);
            if (!pick_vld && !bus.i_engine_busy[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // A free engine is checked before the timeout, so an engine freed in
    // the expiry cycle still wins the packet. A release from the granted
    // engine takes priority over an upstream abort in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (avail) state_nxt = S_SELECT;
            S_SELECT: begin
                if (!avail)                   state_nxt = S_IDLE;
                else if (pick_vld)            state_nxt = S_GRANT;
                else if (timer == TIMER_LAST) state_nxt = S_DROP;
            end
            S_GRANT: begin
                if (bus.i_engine_packet_read_discard[sel]) state_nxt = S_RELEASE;
                else if (!avail)                           state_nxt = S_IDLE;
            end
            S_DROP:    state_nxt = S_RELEASE;
            S_RELEASE: if (!avail) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            sel      <= '0;
            last     <= SEL_W'(ENGINES - 1);
            timer    <= '0;
            cnt_disp <= '0;
            cnt_drop <= '0;
        end else begin
            case (state)
                S_IDLE: if (avail) timer <= '0;
                S_SELECT: begin
                    if (avail) begin
                        if (pick_vld) begin
                            sel      <= pick;
                            last     <= pick;
                            cnt_disp <= cnt_disp + 32'd1;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                S_DROP:  cnt_drop <= cnt_drop + 32'd1;
                default: ;
            endcase
        end
    end

    // Routing is purely combinational from the registered grant so the
    // engine sees the FIFO as if directly connected.
    always_comb begin
        eng_avail  = '0;
        eng_empty  = '1;
        up_rd_en   = 1'b0;
        up_release = 1'b0;
        case (state)
            S_GRANT: begin
                eng_avail[sel] = avail;
                eng_empty[sel] = bus.i_dispatch_fifo_empty;
                up_rd_en       = bus.i_engine_fifo_rd_en[sel];
                up_release     = bus.i_engine_packet_read_discard[sel];
            end
            S_DROP:  up_release = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_busy                         = (state != S_IDLE);
    assign bus.o_dispatch_packet_read_discard = up_release;
    assign bus.o_dispatch_fifo_rd_en          = up_rd_en;
    assign bus.o_engine_packet_available      = eng_avail;
    assign bus.o_engine_fifo_empty            = eng_empty;
    assign bus.o_engine_data_valid            = bus.i_dispatch_data_valid;
    assign bus.o_engine_fifo_rd_data          = bus.i_dispatch_fifo_rd_data;
    assign bus.o_stat_dispatched              = cnt_disp;
    assign bus.o_stat_dropped                 = cnt_drop;
endmodule

// File: tb/tb_nts_dispatch_arbiter.sv
module tb_nts_dispatch_arbiter;
    localparam int ENGINES = 4;
    localparam int DTO     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nts_dispatch_arbiter_if #(.ENGINES(ENGINES)) bus ();

    nts_dispatch_arbiter #(.ENGINES(ENGINES), .DROP_TIMEOUT(DTO)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole packet through a free engine: expect grant to 'exp', release it.
    task automatic run_packet(input string tag, input logic [3:0] exp);
        bus.i_dispatch_packet_available = 1'b1;
        bus.i_dispatch_fifo_empty       = 1'b0;
        tick();                                   // SELECT
        chk({tag, "_sel_avail"}, bus.o_engine_packet_available, 4'b0000);
        tick();                                   // GRANT
        chk({tag, "_grant"}, bus.o_engine_packet_available, exp);
        bus.i_engine_packet_read_discard = exp;
        #1;
        chk({tag, "_rel_fwd"}, bus.o_dispatch_packet_read_discard, 1'b1);
        tick();                                   // RELEASE
        bus.i_engine_packet_read_discard = '0;
        bus.i_dispatch_packet_available  = 1'b0;
        bus.i_dispatch_fifo_empty        = 1'b1;
        tick();                                   // IDLE
        chk({tag, "_idle"}, bus.o_busy, 1'b0);
    endtask

    initial begin
        bus.i_dispatch_packet_available  = 1'b0;
        bus.i_dispatch_data_valid        = 8'h00;
        bus.i_dispatch_fifo_empty        = 1'b1;
        bus.i_dispatch_fifo_rd_data      = 64'h0;
        bus.i_engine_busy                = '0;
        bus.i_engine_packet_read_discard = '0;
        bus.i_engine_fifo_rd_en          = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy",  bus.o_busy, 1'b0);
        chk("rst_rdd",   bus.o_dispatch_packet_read_discard, 1'b0);
        chk("rst_rden",  bus.o_dispatch_fifo_rd_en, 1'b0);
        chk("rst_avail", bus.o_engine_packet_available, 4'b0000);
        chk("rst_empty", bus.o_engine_fifo_empty, 4'b1111);
        chk("rst_disp",  bus.o_stat_dispatched, 32'd0);
        chk("rst_drop",  bus.o_stat_dropped, 32'd0);
        rst_n = 1'b1;
        tick();

        // One 90-byte request to engine 0: 12 words, last word 2 bytes valid
        bus.i_dispatch_packet_available = 1'b1;
        bus.i_dispatch_fifo_empty       = 1'b0;
        bus.i_dispatch_data_valid       = 8'h03;
        tick();
        chk("t1_busy", bus.o_busy, 1'b1);
        chk("t1_sel_avail", bus.o_engine_packet_available, 4'b0000);
        tick();
        chk("t1_avail", bus.o_engine_packet_available, 4'b0001);
        chk("t1_empty", bus.o_engine_fifo_empty, 4'b1110);
        chk("t1_disp",  bus.o_stat_dispatched, 32'd1);
        chk("t1_dv",    bus.o_engine_data_valid, 8'h03);
        bus.i_engine_fifo_rd_en = 4'b0010;        // non-selected pop ignored
        #1;
        chk("t1_ignore_rden", bus.o_dispatch_fifo_rd_en, 1'b0);
        for (int w = 0; w < 12; w++) begin
            bus.i_engine_fifo_rd_en     = 4'b0001;
            bus.i_dispatch_fifo_rd_data = 64'hA5A5_0000_0000_0000 + 64'(w);
            #1;
            chk("t1_rden", bus.o_dispatch_fifo_rd_en, 1'b1);
            chk("t1_data", bus.o_engine_fifo_rd_data, 64'hA5A5_0000_0000_0000 + 64'(w));
            tick();
        end
        bus.i_engine_fifo_rd_en   = '0;
        bus.i_dispatch_fifo_empty = 1'b1;
        #1;
        chk("t1_empty_end", bus.o_engine_fifo_empty, 4'b1111);
        bus.i_engine_packet_read_discard = 4'b0001;
        #1;
        chk("t1_rdd", bus.o_dispatch_packet_read_discard, 1'b1);
        tick();                                   // RELEASE
        bus.i_engine_packet_read_discard = '0;
        #1;
        chk("t1_rel_rdd",   bus.o_dispatch_packet_read_discard, 1'b0);
        chk("t1_rel_avail", bus.o_engine_packet_available, 4'b0000);
        chk("t1_rel_busy",  bus.o_busy, 1'b1);
        bus.i_dispatch_packet_available = 1'b0;
        tick();
        chk("t1_idle", bus.o_busy, 1'b0);
        chk("t1_disp_end", bus.o_stat_dispatched, 32'd1);

        // Fresh reset, then round robin 0,1,2,3,0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        run_packet("rr0", 4'b0001);
        run_packet("rr1", 4'b0010);
        run_packet("rr2", 4'b0100);
        run_packet("rr3", 4'b1000);
        run_packet("rr4", 4'b0001);
        chk("rr_disp", bus.o_stat_dispatched, 32'd5);

        // last=0, engine 1 busy -> engine 2
        bus.i_engine_busy = 4'b0010;
        run_packet("skip1", 4'b0100);
        bus.i_engine_busy = 4'b0000;
        chk("skip_disp", bus.o_stat_dispatched, 32'd6);

        // All busy: drop after DTO cycles in SELECT
        bus.i_engine_busy               = 4'b1111;
        bus.i_dispatch_packet_available = 1'b1;
        bus.i_dispatch_fifo_empty       = 1'b0;
        tick();                                   // SELECT, timer 0
        for (int i = 0; i < DTO; i++) begin
            chk("drop_wait_rdd", bus.o_dispatch_packet_read_discard, 1'b0);
            chk("drop_wait_avail", bus.o_engine_packet_available, 4'b0000);
            tick();
        end
        chk("drop_rdd", bus.o_dispatch_packet_read_discard, 1'b1);
        tick();                                   // RELEASE
        chk("drop_rdd_once", bus.o_dispatch_packet_read_discard, 1'b0);
        chk("drop_cnt",  bus.o_stat_dropped, 32'd1);
        chk("drop_disp", bus.o_stat_dispatched, 32'd6);
        bus.i_dispatch_packet_available = 1'b0;
        bus.i_dispatch_fifo_empty       = 1'b1;
        tick();
        chk("drop_idle", bus.o_busy, 1'b0);

        // Engine 3 freed in the expiry cycle wins (last=2)
        bus.i_dispatch_packet_available = 1'b1;
        bus.i_dispatch_fifo_empty       = 1'b0;
        tick();                                   // SELECT, timer 0
        for (int i = 0; i < DTO - 1; i++) tick(); // timer DTO-1
        chk("late_rdd", bus.o_dispatch_packet_read_discard, 1'b0);
        bus.i_engine_busy = 4'b0111;
        tick();
        chk("late_grant", bus.o_engine_packet_available, 4'b1000);
        chk("late_drop",  bus.o_stat_dropped, 32'd1);
        chk("late_disp",  bus.o_stat_dispatched, 32'd7);
        bus.i_engine_busy = 4'b1111;              // busy during own grant
        tick();
        chk("late_keep", bus.o_engine_packet_available, 4'b1000);
        bus.i_engine_busy                = 4'b0000;
        bus.i_engine_packet_read_discard = 4'b1000;
        tick();
        bus.i_engine_packet_read_discard = '0;
        bus.i_dispatch_packet_available  = 1'b0;
        bus.i_dispatch_fifo_empty        = 1'b1;
        tick();
        chk("late_idle", bus.o_busy, 1'b0);

        // Reset mid-GRANT, packet re-arbitrated to engine 0
        bus.i_dispatch_packet_available = 1'b1;
        bus.i_dispatch_fifo_empty       = 1'b0;
        tick();
        tick();
        chk("mr_grant", bus.o_engine_packet_available, 4'b0001);
        bus.i_engine_fifo_rd_en = 4'b0001;
        #1;
        chk("mr_rden", bus.o_dispatch_fifo_rd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_avail", bus.o_engine_packet_available, 4'b0000);
        chk("mr_empty", bus.o_engine_fifo_empty, 4'b1111);
        chk("mr_rden0", bus.o_dispatch_fifo_rd_en, 1'b0);
        chk("mr_busy",  bus.o_busy, 1'b0);
        chk("mr_disp0", bus.o_stat_dispatched, 32'd0);
        bus.i_engine_fifo_rd_en = '0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("mr_regrant", bus.o_engine_packet_available, 4'b0001);
        chk("mr_disp1",   bus.o_stat_dispatched, 32'd1);

        // Upstream abort in GRANT: back to IDLE, no drop counted
        bus.i_dispatch_packet_available = 1'b0;
        bus.i_dispatch_fifo_empty       = 1'b1;
        tick();
        chk("abort_idle", bus.o_busy, 1'b0);
        chk("abort_drop", bus.o_stat_dropped, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
